// File: rtl/ram_fifo_ctrl_if.sv
// rtl/ram_fifo_ctrl_if.sv - write/read stream handshake bundle for ram_fifo_ctrl
interface ram_fifo_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller around a single-port, 1-cycle-latency block RAM
module ram_fifo_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH),
  localparam int FW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  ram_fifo_ctrl_if.slave   bus,
  output logic [FW-1:0]    fill,
  output logic             full,
  output logic             empty,
  output logic             ram_write_en,
  output logic             ram_read_en,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_data_in,
  input  logic [WIDTH-1:0] ram_data_out
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             rd_inflight_q, rd_inflight_d;
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             rd_issue;
  logic             push;

  // Explicit wrap so non-power-of-two depths stay in range.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full  = (fill_q == FW'(DEPTH));
  assign empty = (fill_q == '0);
  assign fill  = fill_q;

  // Reads win the port; the in-flight gap guarantees a free write slot every other cycle.
  assign rd_issue    = !empty && !rd_inflight_q && (!m_valid_q || bus.m_ready) && !flush;
  assign bus.s_ready = !full && !rd_issue && !flush && rst_n;
  assign push        = bus.s_valid && bus.s_ready;

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;

  always_comb begin
    ram_write_en = 1'b0;
    ram_read_en  = 1'b0;
    ram_addr     = '0;
    ram_data_in  = '0;
    if (rd_issue) begin
      ram_read_en = 1'b1;
      ram_addr    = rd_ptr_q;
    end else if (push) begin
      ram_write_en = 1'b1;
      ram_addr     = wr_ptr_q;
      ram_data_in  = bus.s_data;
    end
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fill_d        = fill_q;
    rd_inflight_d = rd_inflight_q;
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    if (flush) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      fill_d        = '0;
      rd_inflight_d = 1'b0;
      m_valid_d     = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
        fill_d   = fill_q + FW'(1);
      end
      if (rd_issue) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        fill_d   = fill_q - FW'(1);
      end
      rd_inflight_d = rd_issue;
      // A landing return takes precedence over a same-cycle consume.
      if (rd_inflight_q) begin
        m_valid_d = 1'b1;
        m_data_d  = ram_data_out;
      end else if (m_valid_q && bus.m_ready) begin
        m_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fill_q        <= '0;
      rd_inflight_q <= 1'b0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fill_q        <= fill_d;
      rd_inflight_q <= rd_inflight_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - scoreboard bench for ram_fifo_ctrl with a behavioural block RAM
module tb_ram_fifo_ctrl;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = AW + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.WIDTH(WIDTH)) bus();

  logic [FW-1:0]    fill;
  logic             full, empty, ram_write_en, ram_read_en;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_data_in, ram_data_out;

  ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus),
    .fill         (fill),
    .full         (full),
    .empty        (empty),
    .ram_write_en (ram_write_en),
    .ram_read_en  (ram_read_en),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_addr] <= ram_data_in;
    if (ram_read_en)  ram_q <= mem[ram_addr];
  end
  assign ram_data_out = ram_q;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_q [$];
  int wr_cnt = 0;
  int rd_cnt = 0;
  bit rand_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: words leave in acceptance order; k-th write since clear goes to k mod DEPTH.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      wr_cnt = 0;
      rd_cnt = 0;
    end else if (flush) begin
      chk("flush_quiet", {29'd0, ram_write_en, ram_read_en, bus.s_ready}, 32'd0);
      exp_q.delete();
      wr_cnt = 0;
      rd_cnt = 0;
    end else begin
      chk("fill", 32'(fill), 32'(wr_cnt - rd_cnt));
      chk("full", 32'(full), 32'((wr_cnt - rd_cnt) == DEPTH));
      chk("empty", 32'(empty), 32'((wr_cnt - rd_cnt) == 0));
      chk("port_excl", 32'(ram_write_en && ram_read_en), 32'd0);
      chk("wr_handshake", 32'(ram_write_en), 32'(bus.s_valid && bus.s_ready));
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) chk("pop_nonempty", 32'(exp_q.size()), 32'd1);
        else chk("m_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
      end
      if (bus.s_valid && bus.s_ready) begin
        chk("wr_addr", 32'(ram_addr), 32'(wr_cnt % DEPTH));
        chk("wr_data", 32'(ram_data_in), 32'(bus.s_data));
        exp_q.push_back(bus.s_data);
        wr_cnt++;
      end
      if (ram_read_en) begin
        chk("rd_addr", 32'(ram_addr), 32'(rd_cnt % DEPTH));
        rd_cnt++;
      end
      if (!ram_write_en && !ram_read_en)
        chk("idle_ram", {12'd0, 2'(ram_addr), ram_data_in}, 32'd0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
  end

  task automatic push(input logic [WIDTH-1:0] d);
    bit ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("push_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.m_valid && fill == '0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_done", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_ram_we", 32'(ram_write_en), 32'd0);
    chk("rst_ram_re", 32'(ram_read_en), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din", 32'(ram_data_in), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two pushes held in the output path
    push(16'hABCD);
    push(16'h1234);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_m_valid", 32'(bus.m_valid), 32'd1);
    chk("t1_m_data", 32'(bus.m_data), 32'hABCD);
    chk("t1_fill", 32'(fill), 32'd1);

    // Consume: next word returns two cycles after the handshake
    @(posedge clk);
    #1 bus.m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t2_gap", 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    chk("t2_m_valid", 32'(bus.m_valid), 32'd1);
    chk("t2_m_data", 32'(bus.m_data), 32'h1234);
    chk("t2_fill", 32'(fill), 32'd0);
    @(negedge clk);
    chk("t2_done_valid", 32'(bus.m_valid), 32'd0);
    chk("t2_done_empty", 32'(empty), 32'd1);
    @(posedge clk);
    #1 bus.m_ready = 1'b0;

    // Fill to full with one word parked in the output register
    for (int i = 0; i < 5; i++) push(WIDTH'(16'h0A00 + i));
    @(negedge clk);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_fill", 32'(fill), 32'(DEPTH));
    chk("t3_m_valid", 32'(bus.m_valid), 32'd1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h0A05;
    @(negedge clk);
    chk("t3_s_ready_full", 32'(bus.s_ready), 32'd0);
    chk("t3_no_write_full", 32'(ram_write_en), 32'd0);
    @(posedge clk);
    #1 bus.m_ready = 1'b1;
    push(16'h0A05);
    drain();

    // Random streaming: steady m_ready, then random back-pressure
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) rand_ready = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      push(WIDTH'($urandom));
    end
    rand_ready = 1'b0;
    drain();

    // Flush with fill=3 and a read in flight
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(WIDTH'(16'h0F00 + i));
    @(posedge clk);
    #1 bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("t5_pre_fill", 32'(fill), 32'd3);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("t5_fill", 32'(fill), 32'd0);
    chk("t5_m_valid", 32'(bus.m_valid), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    @(posedge clk);
    #1;
    push(16'h5555);
    drain();

    // Asynchronous reset between edges
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(WIDTH'(16'h0C00 + i));
    @(posedge clk);
    #1;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h7777;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #2 rst_n = 1'b1;
    push(16'h7777);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
